// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
package imem_loader_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_CNT_W = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StChk,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/byte_word_packer.sv
// Packs accepted stream bytes LSB-first into 32-bit words and keeps a running XOR.
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_done,
  output logic [31:0] word,
  output logic [7:0]  xor_sum
);

  logic [BYTE_CNT_W-1:0] cnt_q;
  logic [23:0]           hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      hold_q  <= '0;
      xor_sum <= '0;
    end else if (clear) begin
      cnt_q   <= '0;
      hold_q  <= '0;
      xor_sum <= '0;
    end else if (byte_valid) begin
      cnt_q   <= cnt_q + BYTE_CNT_W'(1);
      xor_sum <= xor_sum ^ byte_in;
      case (cnt_q)
        BYTE_CNT_W'(0): hold_q[7:0]   <= byte_in;
        BYTE_CNT_W'(1): hold_q[15:8]  <= byte_in;
        BYTE_CNT_W'(2): hold_q[23:16] <= byte_in;
        default:        hold_q        <= hold_q;
      endcase
    end
  end

  // The last byte bypasses the holding register so the word is usable in the accept cycle.
  assign word_done = byte_valid && (cnt_q == BYTE_CNT_W'(WORD_BYTES - 1));
  assign word      = {byte_in, hold_q};

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: length, instruction words, XOR checksum -> imem writes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
  parameter int unsigned            MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_hold
);

  state_e                state;
  logic [15:0]           count;
  logic [15:0]           idx;
  logic                  accept;
  logic                  pack_valid;
  logic                  word_done;
  logic [31:0]           packed_word;
  logic [7:0]            xor_sum;
  logic [15:0]           len_full;
  logic [ADDR_WIDTH-1:0] word_addr;

  assign rx_ready   = state inside {StLenLo, StLenHi, StData, StChk};
  assign busy       = rx_ready;
  assign accept     = rx_valid && rx_ready;
  assign pack_valid = accept && !start && (state == StData);
  assign len_full   = {rx_data, count[7:0]};
  assign word_addr  = BASE_ADDR + ADDR_WIDTH'({idx, 2'b00});

  byte_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start),
    .byte_valid (pack_valid),
    .byte_in    (rx_data),
    .word_done  (word_done),
    .word       (packed_word),
    .xor_sum    (xor_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      count    <= '0;
      idx      <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= BASE_ADDR;
      wr_data  <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      wr_en <= 1'b0;
      // start overrides everything, including a byte offered in the same cycle
      if (start) begin
        state    <= StLenLo;
        count    <= '0;
        idx      <= '0;
        done     <= 1'b0;
        error    <= 1'b0;
        cpu_hold <= 1'b1;
      end else begin
        case (state)
          StLenLo: begin
            if (accept) begin
              count[7:0] <= rx_data;
              state      <= StLenHi;
            end
          end
          StLenHi: begin
            if (accept) begin
              count[15:8] <= rx_data;
              if (len_full == 16'd0) begin
                state <= StChk;
              end else if (32'(len_full) > MAX_WORDS) begin
                state <= StErr;
                error <= 1'b1;
              end else begin
                state <= StData;
              end
            end
          end
          StData: begin
            if (word_done) begin
              wr_en   <= 1'b1;
              wr_addr <= word_addr;
              wr_data <= packed_word;
              idx     <= idx + 16'd1;
              if ((idx + 16'd1) == count) begin
                state <= StChk;
              end
            end
          end
          StChk: begin
            if (accept) begin
              if (rx_data == xor_sum) begin
                state    <= StDone;
                done     <= 1'b1;
                cpu_hold <= 1'b0;
              end else begin
                state <= StErr;
                error <= 1'b1;
              end
            end
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader with a stream-level reference model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .cpu_hold (cpu_hold)
  );

  int checks = 0;
  int failures = 0;
  int cmp_checks = 0;
  int cmp_failures = 0;
  int wr_seen = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] words[16];

  function automatic logic [7:0] word_xor(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Every write strobe seen must match the next expected (addr, data) in order.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      cmp_checks++;
      if (wr_seen >= exp_addr.size()) begin
        cmp_failures++;
        $display("FAIL wr_unexpected: got addr %h data %h, want no write", wr_addr, wr_data);
      end else if (wr_addr !== exp_addr[wr_seen] || wr_data !== exp_data[wr_seen]) begin
        cmp_failures++;
        $display("FAIL wr_match: got addr %h data %h want addr %h data %h",
                 wr_addr, wr_data, exp_addr[wr_seen], exp_data[wr_seen]);
      end
      wr_seen++;
    end
  end

  task automatic check_reset_vals();
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_cpu_hold", cpu_hold, 1);
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_byte(input logic [7:0] b, input int gmode);
    int g;
    g = (gmode == 0) ? 0 : (gmode == 1) ? 1 : int'($urandom_range(0, 3));
    rx_valid = 1'b0;
    repeat (g) begin
      rx_data = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 50 && !rx_ready; i++) @(negedge clk);
    if (!rx_ready) begin
      checks++;
      failures++;
      $display("FAIL rx_ready_timeout: got 0 want 1");
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    rx_valid = 1'b0;
    chk("start_rx_ready", rx_ready, 1);
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_error", error, 0);
    chk("start_cpu_hold", cpu_hold, 1);
  endtask

  task automatic run_load(input int n, input bit bad, input int gmode);
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [15:0] len;
    logic [31:0] w;
    cs  = 8'h00;
    len = 16'(n);
    send_byte(len[7:0], gmode);
    send_byte(len[15:8], gmode);
    if (n > 1024) begin
      chk("ovs_error", error, 1);
      chk("ovs_done", done, 0);
      chk("ovs_rx_ready", rx_ready, 0);
      chk("ovs_cpu_hold", cpu_hold, 1);
      rx_valid = 1'b1;
      repeat (6) begin
        rx_data = 8'($urandom);
        @(negedge clk);
      end
      rx_valid = 1'b0;
      chk("ovs_error_hold", error, 1);
      chk("ovs_rx_ready_hold", rx_ready, 0);
      chk("ovs_wr_count", wr_seen, exp_addr.size());
      return;
    end
    for (int k = 0; k < n; k++) begin
      w = words[k];
      exp_addr.push_back(32'(4 * k));
      exp_data.push_back(w);
      for (int j = 0; j < 4; j++) begin
        b  = w[8*j +: 8];
        cs = cs ^ b;
        send_byte(b, gmode);
      end
    end
    if (bad) cs = cs ^ 8'($urandom_range(1, 255));
    send_byte(cs, gmode);
    chk("end_done", done, {31'b0, !bad});
    chk("end_error", error, {31'b0, bad});
    chk("end_cpu_hold", cpu_hold, {31'b0, bad});
    chk("end_busy", busy, 0);
    chk("end_rx_ready", rx_ready, 0);
    chk("end_wr_count", wr_seen, exp_addr.size());
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #12;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals();

    chk("model_xor1", word_xor(32'hE3A00014), 32'h57);
    chk("model_xor3", word_xor(32'hE3A00014) ^ word_xor(32'hE3A01A01) ^ word_xor(32'hE3A02103),
        32'h6E);

    // Single word, continuous valid
    words[0] = 32'hE3A00014;
    pulse_start();
    run_load(1, 1'b0, 0);
    chk("single_wr_data", exp_data[0], 32'hE3A00014);

    // Bad checksum, then recover
    pulse_start();
    run_load(1, 1'b1, 0);
    pulse_start();
    run_load(1, 1'b0, 0);

    // Three words, valid toggling
    words[1] = 32'hE3A01A01;
    words[2] = 32'hE3A02103;
    pulse_start();
    run_load(3, 1'b0, 1);

    // Zero count and oversize count
    pulse_start();
    run_load(0, 1'b0, 0);
    pulse_start();
    run_load(1025, 1'b0, 0);

    // Abort after two data bytes; start collides with a byte offer
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h14, 0);
    send_byte(8'h00, 0);
    rx_valid = 1'b1;
    rx_data  = 8'hA0;
    pulse_start();
    run_load(1, 1'b0, 0);

    // Randomized loads
    for (int it = 0; it < 30; it++) begin
      n = int'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) n = 1025 + int'($urandom_range(0, 60000));
      for (int k = 0; k < 16; k++) words[k] = $urandom;
      pulse_start();
      run_load(n, $urandom_range(0, 3) == 0, int'($urandom_range(0, 2)));
    end

    // Asynchronous reset while a write strobe is pending
    words[0] = 32'hE3A00014;
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    rx_valid = 1'b1;
    rx_data  = 8'h44;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    rx_valid = 1'b0;
    check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals();
    pulse_start();
    run_load(1, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks + cmp_checks, failures + cmp_failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream loader that fills the writable instruction memory before the ARM pipeline runs. It accepts a framed byte stream on a valid/ready handshake: a 16-bit little-endian word count, then the instruction words (each 4 bytes, LSB first), then an XOR checksum byte. It issues one memory write per assembled word and holds the CPU until the image is complete and verified. It sits between the host/UART receiver and the instruction-memory write port, and replaces hard-coded program contents.

## Interface
- ADDR_WIDTH, 32, width of wr_addr (byte address)
- BASE_ADDR, 0, byte address of word 0
- MAX_WORDS, 1024, largest accepted word count
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; arms (or re-arms) a load
- rx_data  in  8  stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader can accept a byte
- wr_en  out  1  one-cycle instruction-memory write strobe
- wr_addr  out  ADDR_WIDTH  byte address of write, word-aligned
- wr_data  out  32  instruction word
- busy  out  1  load in progress
- done  out  1  image loaded and checksum matched (level)
- error  out  1  checksum mismatch or oversize count (level)
- cpu_hold  out  1  keeps the pipeline stalled/reset while high

## Operation
- A byte is accepted on a cycle where rx_valid && rx_ready. Nothing else consumes a byte.
- States and outputs:
  - IDLE: rx_ready=0.
  - LEN_LO: on accept, count[7:0] is loaded.
  - LEN_HI: on accept, count[15:8] is loaded. If count==0, go to CHK. If count>MAX_WORDS, go to ERR. Otherwise go to DATA.
  - DATA: bytes are packed LSB first, byte0→[7:0] through byte3→[31:24]. On the 4th byte, the word is written and idx increments. After word count−1 is written, go to CHK.
  - CHK: on accept, the byte is compared with the running XOR of all DATA bytes (length bytes excluded). A match goes to DONE; a mismatch goes to ERR.
  - DONE: done=1, cpu_hold=0, rx_ready=0.
  - ERR: error=1, cpu_hold=1, rx_ready=0.
- rx_ready=1 exactly in LEN_LO, LEN_HI, DATA and CHK. It is decoded from state, with no backpressure inside DATA.
- Write address: word k is written to BASE_ADDR + 4·k. Arithmetic is modulo 2^ADDR_WIDTH.
- start in any state returns to LEN_LO. This clears done, error, idx, the checksum and the byte counter, and sets cpu_hold=1.
  - start mid-load aborts that load. Words already written stay written.
- start in the same cycle as a byte accept: start wins and the byte is dropped.
- Bytes presented in IDLE, DONE or ERR are ignored because rx_ready=0.

## Timing
- Reset values: state=IDLE, rx_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, busy=0, done=0, error=0, cpu_hold=1. The CPU stays held until the first successful load.
- start at cycle t puts the block in LEN_LO at t+1, with busy=1 and rx_ready=1.
- When the 4th byte of word k is accepted at cycle t:
  - wr_en=1 during cycle t+1 only.
  - wr_addr and wr_data are registered and stable during t+1.
  - rx_ready stays high, so the next word's byte 0 may be accepted in cycle t+1.
- Checksum byte accepted at cycle t: from t+1, done or error is high, cpu_hold follows, and busy=0.
- Oversize count: ERR is entered the cycle after LEN_HI is accepted, and no wr_en is issued.
- Minimum load time with continuous rx_valid: 3 + 4·N cycles of accepts after LEN_LO is entered, plus 1 cycle to DONE.
- Reset asserted mid-operation forces all reset values immediately (asynchronously). A pending wr_en is cancelled.

## Structure
- Package imem_loader_pkg holds:
  - the state enum (IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR);
  - the WORD_BYTES=4 constant;
  - the byte-count width.
- One natural sub-module, byte_word_packer, owns:
  - the 2-bit byte counter and the shift/pack of 4 bytes into 32 bits;
  - the word-complete pulse and the running XOR.
- The top level holds the FSM, the word index/address counter and the output registers.

## Test plan
- Single word. start; bytes 01 00 14 00 A0 E3 57 with continuous valid. Required: exactly one wr_en, addr 0x0, data 0xE3A00014; then done=1, cpu_hold=0, error=0.
- Bad checksum. Same stream with final byte 58. Required: one write of 0xE3A00014; then error=1, done=0, cpu_hold=1. A new start then the correct stream gives done=1.
- Multi-word with gaps. N=3 (03 00), words E3A00014, E3A01A01, E3A02103, correct checksum, rx_valid toggling every other cycle. Required: writes at 0x0, 0x4, 0x8 in order with those data, each wr_en exactly one cycle, then done.
- Edge counts.
  - Case 1: 00 00 00. Required: done, no wr_en.
  - Case 2: 01 04 (count 1025 > MAX_WORDS). Required: error one cycle after byte 04 and rx_ready=0 thereafter.
- Abort and reset.
  - Case 1: start pulsed after 2 DATA bytes. Required: back in LEN_LO; a fresh single-word stream loads at addr 0x0.
  - Case 2: rst asserted mid-DATA. Required: all outputs at reset values the same cycle and no spurious wr_en.
